chunked_serial_adder: RTL

- Multi-cycle, parametrised-width two's-complement adder with a registered inter-chunk carry.
- Processes one CHUNK-bit slice per clock, so a wide add reuses a narrow carry chain.
- Valid/ready handshake on both input and output sides.
- Used where area matters more than throughput: accumulators, address generators, wide counters in slow datapaths.

---
 rtl/chunked_serial_adder_if.sv | 36 +++
 rtl/chunked_serial_adder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder_if.sv
// Operand/result handshake bundle for chunked_serial_adder.
// Zero latency (wires only); valid/ready on both operand and result sides.
// The optional sub lane exists only when CHUNKED_ADDER_SUB_EN is defined.
interface chunked_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CHUNKED_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
`ifdef CHUNKED_ADDER_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
`ifdef CHUNKED_ADDER_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/chunked_serial_adder.sv
// Serial two's-complement adder, one CHUNK-bit slice per clock; CHUNKED_ADDER_SUB_EN adds a subtract mode.
// Latency: out_valid rises WIDTH/CHUNK edges after the accepting edge; II = WIDTH/CHUNK + 2.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE, no operand queueing.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    chunked_serial_adder_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, sum_shift;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [CHUNK:0]   slice;
    logic             msb_cin;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    // Operands shift right each slice, so the active slice is always the low CHUNK bits.
    assign slice   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    assign msb_cin = slice[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];

    generate
        if (CHUNK == WIDTH) begin : g_single
            assign sum_shift = slice[CHUNK-1:0];
        end else begin : g_multi
            assign sum_shift = {slice[CHUNK-1:0], sum_q[WIDTH-1:CHUNK]};
        end
    endgenerate

`ifdef CHUNKED_ADDER_SUB_EN
    assign b_in = bus.sub ? ~bus.b : bus.b;
    assign c_in = bus.sub | bus.cin & ~bus.sub;
`else
    assign b_in = bus.b;
    assign c_in = bus.cin;
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d        = bus.a;
                    b_d        = b_in;
                    carry_d    = c_in;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                sum_d   = sum_shift;
                carry_d = slice[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cout_d      = slice[CHUNK];
                    ovf_d       = msb_cin ^ slice[CHUNK];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule
